wordle_guess_buffer: RTL and testbench
======================================

WORDLE_GUESS_BUFFER -- requirements
Module: wordle_guess_buffer

Interface
REQ-001 The block SHALL have parameter MAX_GUESSES, default 6, meaning the number of guesses allowed per game (1..7).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- Clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  level; begins a game from QI.
- Ack  input  1  level; returns QDONE to QI.
- Sel  input  1  level select button, debounced upstream.
- curr_letter  input  8  ASCII of the highlighted key: 'A'..'Z', ',' (delete) or '.' (enter).
- guess_ack  input  1  checker accepted the presented guess.
- guess  output  40  letter 0 in [39:32] through letter 4 in [7:0]; unused slots 8'h20.
- letter_cnt  output  3  letters entered, 0..5.
- guess_num  output  3  guesses consumed, 0..MAX_GUESSES.
- guess_valid  output  1  guess presented to checker.
- q_I, q_Entry, q_Submit, q_Done  output  1 each  one-hot state flags.

Function
REQ-003 State encoding SHALL be one-hot: QI=4'b1000, QENTRY=4'b0100, QSUBMIT=4'b0010, QDONE=4'b0001.
REQ-004 A Sel press SHALL be a 0->1 transition of Sel between consecutive clocks, detected with a registered copy of Sel; holding Sel SHALL yield exactly one press.
REQ-005 QI: on Start, the block SHALL clear guess to all 8'h20, set letter_cnt=0 and guess_num=0, and enter QENTRY on the next edge.
REQ-006 QENTRY, press with 'A'..'Z' and letter_cnt<5: the block SHALL write curr_letter into slot letter_cnt and increment letter_cnt.
REQ-007 QENTRY, press with 'A'..'Z' and letter_cnt==5: the block SHALL ignore the press.
REQ-008 QENTRY, press with ',' and letter_cnt>0: the block SHALL decrement letter_cnt and write 8'h20 into slot letter_cnt-1. With letter_cnt==0 the press SHALL be ignored.
REQ-009 QENTRY, press with '.' and letter_cnt==5: the block SHALL enter QSUBMIT. With letter_cnt<5 the press SHALL be ignored.
REQ-010 Any other curr_letter value on a press SHALL be ignored.
REQ-011 guess_valid SHALL be 1 exactly while in QSUBMIT, and guess SHALL be held stable while guess_valid is 1.
REQ-012 QSUBMIT on guess_ack: the block SHALL increment guess_num, clear guess to all 8'h20, and set letter_cnt=0.
REQ-013 After REQ-012, if the new guess_num equals MAX_GUESSES the block SHALL enter QDONE; otherwise it SHALL enter QENTRY.
REQ-014 Sel presses in QSUBMIT, QDONE and QI SHALL have no effect.
REQ-015 QDONE: on Ack the block SHALL enter QI. guess_num SHALL be held until the next Start.
REQ-016 Latency: each accepted press SHALL be reflected on guess and letter_cnt on the first edge after it is detected, i.e. 1 cycle after Sel rises.
REQ-017 An unknown or illegal state SHALL recover to QI on the next edge.

Reset
REQ-018 While reset_n=0, outputs SHALL be held asynchronously at: state QI, guess all 8'h20, letter_cnt=0, guess_num=0, guess_valid=0, registered Sel=0.
REQ-019 Reset asserted mid-entry or mid-submit SHALL abandon the guess with no partial state retained.

Configuration
REQ-020 Macro GUESS_REJECT_EN SHALL control whether the checker can reject a guess.
REQ-021 With GUESS_REJECT_EN defined: input guess_reject (1 bit) SHALL be added. In QSUBMIT, guess_reject=1 SHALL return the block to QENTRY with guess and letter_cnt=5 retained and guess_num unchanged. If guess_ack and guess_reject are both 1, guess_reject SHALL win.
REQ-022 Without GUESS_REJECT_EN: the guess_reject port SHALL NOT exist, and every guess_ack SHALL consume a guess.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Start; press H,E,L,L,O then '.' -> guess=40'h48454C4C4F, guess_valid=1; guess_ack -> guess_num=1, letter_cnt=0, QENTRY.
- Enter 5 letters; press 'Z' -> ignored, guess unchanged; press ',' -> letter_cnt=4, [7:0]=8'h20.
- letter_cnt=3; press '.' -> still QENTRY. letter_cnt=0; press ',' -> no change.
- Hold Sel high 20 cycles on 'A' -> exactly one letter, letter_cnt=1.
- MAX_GUESSES=6; six acked guesses -> QDONE, guess_num=6; Ack -> QI.
- GUESS_REJECT_EN; guess_ack and guess_reject together -> QENTRY, letter_cnt=5, guess_num unchanged.
- Drop reset_n during QSUBMIT -> immediately QI, guess_valid=0.

Source files
------------

// File: rtl/wordle_guess_buffer.sv
// Guess entry buffer for a Wordle-style game: collects up to five letters from Sel presses and hands them to a checker.
// Define GUESS_REJECT_EN to add the guess_reject input, which lets the checker bounce a guess back for editing.
module wordle_guess_buffer #(
  parameter int MAX_GUESSES = 6
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic        Ack,
  input  logic        Sel,
  input  logic [7:0]  curr_letter,
  input  logic        guess_ack,
`ifdef GUESS_REJECT_EN
  input  logic        guess_reject,
`endif
  output logic [39:0] guess,
  output logic [2:0]  letter_cnt,
  output logic [2:0]  guess_num,
  output logic        guess_valid,
  output logic        q_I,
  output logic        q_Entry,
  output logic        q_Submit,
  output logic        q_Done
);

  typedef enum logic [3:0] {
    QI     = 4'b1000,
    QENTRY = 4'b0100,
    QSUBMIT= 4'b0010,
    QDONE  = 4'b0001
  } state_t;

  localparam logic [39:0] BLANK     = {5{8'h20}};
  localparam logic [7:0]  KEY_DEL   = 8'h2C;
  localparam logic [7:0]  KEY_ENTER = 8'h2E;

  state_t      state, state_next;
  logic        sel_q;
  logic        press;
  logic        is_alpha;
  logic [39:0] guess_next;
  logic [2:0]  cnt_next;
  logic [2:0]  num_next;

  assign press    = Sel & ~sel_q;
  assign is_alpha = (curr_letter >= 8'h41) && (curr_letter <= 8'h5A);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= QI;
      sel_q      <= 1'b0;
      guess      <= BLANK;
      letter_cnt <= 3'd0;
      guess_num  <= 3'd0;
    end else begin
      state      <= state_next;
      sel_q      <= Sel;
      guess      <= guess_next;
      letter_cnt <= cnt_next;
      guess_num  <= num_next;
    end
  end

  always_comb begin
    state_next = state;
    guess_next = guess;
    cnt_next   = letter_cnt;
    num_next   = guess_num;
    case (state)
      QI: begin
        if (Start) begin
          guess_next = BLANK;
          cnt_next   = 3'd0;
          num_next   = 3'd0;
          state_next = QENTRY;
        end
      end
      QENTRY: begin
        if (press) begin
          if (is_alpha) begin
            if (letter_cnt < 3'd5) begin
              for (int i = 0; i < 5; i++)
                if (3'(i) == letter_cnt) guess_next[39 - 8*i -: 8] = curr_letter;
              cnt_next = letter_cnt + 3'd1;
            end
          end else if (curr_letter == KEY_DEL) begin
            if (letter_cnt != 3'd0) begin
              for (int i = 0; i < 5; i++)
                if (3'(i) == letter_cnt - 3'd1) guess_next[39 - 8*i -: 8] = 8'h20;
              cnt_next = letter_cnt - 3'd1;
            end
          end else if (curr_letter == KEY_ENTER) begin
            if (letter_cnt == 3'd5) state_next = QSUBMIT;
          end
        end
      end
      QSUBMIT: begin
        // A rejected guess goes back for editing untouched, even if the checker also acked it.
`ifdef GUESS_REJECT_EN
        if (guess_reject) begin
          state_next = QENTRY;
        end else
`endif
        if (guess_ack) begin
          num_next   = guess_num + 3'd1;
          guess_next = BLANK;
          cnt_next   = 3'd0;
          state_next = (guess_num + 3'd1 == 3'(MAX_GUESSES)) ? QDONE : QENTRY;
        end
      end
      QDONE: begin
        if (Ack) state_next = QI;
      end
      default: state_next = QI;
    endcase
  end

  assign guess_valid = (state == QSUBMIT);
  assign q_I         = state[3];
  assign q_Entry     = state[2];
  assign q_Submit    = state[1];
  assign q_Done      = state[0];

endmodule

// File: tb/tb_wordle_guess_buffer.sv
// Self-checking bench for wordle_guess_buffer: directed game scenarios plus a randomized phase,
// all compared every cycle against a letter-array model of the game rules.
module tb_wordle_guess_buffer;

  localparam int MAXG = 6;
  localparam logic [39:0] BLANK = {5{8'h20}};

  logic        Clk, reset_n, Start, Ack, Sel, guess_ack;
  logic [7:0]  curr_letter;
`ifdef GUESS_REJECT_EN
  logic        guess_reject;
`endif
  logic [39:0] guess;
  logic [2:0]  letter_cnt, guess_num;
  logic        guess_valid, q_I, q_Entry, q_Submit, q_Done;

  int checks = 0;
  int errors = 0;

  wordle_guess_buffer #(.MAX_GUESSES(MAXG)) dut (
    .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack), .Sel(Sel),
    .curr_letter(curr_letter), .guess_ack(guess_ack),
`ifdef GUESS_REJECT_EN
    .guess_reject(guess_reject),
`endif
    .guess(guess), .letter_cnt(letter_cnt), .guess_num(guess_num),
    .guess_valid(guess_valid), .q_I(q_I), .q_Entry(q_Entry),
    .q_Submit(q_Submit), .q_Done(q_Done)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Game model: mode 0=idle, 1=entry, 2=submitted, 3=done; letters held as a plain array.
  int         m_mode, m_cnt, m_num;
  logic [7:0] m_letters[5];
  logic       m_prev;

  task automatic model_clear();
    for (int i = 0; i < 5; i++) m_letters[i] = 8'h20;
    m_cnt = 0;
  endtask

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      model_clear();
      m_mode = 0;
      m_num  = 0;
      m_prev = 0;
    end else begin
      logic pressed;
      logic rej;
      pressed = Sel && !m_prev;
      m_prev  = Sel;
      rej     = 0;
`ifdef GUESS_REJECT_EN
      rej     = guess_reject;
`endif
      case (m_mode)
        0: if (Start) begin model_clear(); m_num = 0; m_mode = 1; end
        1: if (pressed) begin
             if (curr_letter >= "A" && curr_letter <= "Z") begin
               if (m_cnt < 5) begin m_letters[m_cnt] = curr_letter; m_cnt++; end
             end else if (curr_letter == ",") begin
               if (m_cnt > 0) begin m_cnt--; m_letters[m_cnt] = 8'h20; end
             end else if (curr_letter == ".") begin
               if (m_cnt == 5) m_mode = 2;
             end
           end
        2: if (rej) m_mode = 1;
           else if (guess_ack) begin
             m_num++;
             model_clear();
             m_mode = (m_num == MAXG) ? 3 : 1;
           end
        default: if (Ack) m_mode = 0;
      endcase
    end
  end

  task automatic check(string name, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mode_flags(int mode);
    case (mode)
      0: return 4'b1000;
      1: return 4'b0100;
      2: return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  always @(negedge Clk) begin
    check("guess", guess, {m_letters[0], m_letters[1], m_letters[2], m_letters[3], m_letters[4]});
    check("letter_cnt", 40'(letter_cnt), 40'(m_cnt));
    check("guess_num", 40'(guess_num), 40'(m_num));
    check("guess_valid", 40'(guess_valid), 40'(m_mode == 2));
    check("state", 40'({q_I, q_Entry, q_Submit, q_Done}), 40'(mode_flags(m_mode)));
  end

  task automatic press_key(logic [7:0] l);
    @(negedge Clk);
    curr_letter = l;
    Sel = 1;
    @(negedge Clk);
    Sel = 0;
  endtask

  task automatic type_word(string w);
    for (int i = 0; i < 5; i++) press_key(w[i]);
  endtask

  task automatic start_game();
    @(negedge Clk); Start = 1;
    @(negedge Clk); Start = 0;
  endtask

  task automatic ack_guess();
    @(negedge Clk); guess_ack = 1;
    @(negedge Clk); guess_ack = 0;
  endtask

  initial begin
    reset_n = 0; Sel = 0; Start = 0; Ack = 0; guess_ack = 0; curr_letter = 8'h41;
`ifdef GUESS_REJECT_EN
    guess_reject = 0;
`endif
    repeat (2) @(negedge Clk);
    check("reset_state", 40'({q_I, q_Entry, q_Submit, q_Done}), 40'h8);
    check("reset_guess", guess, BLANK);
    reset_n = 1;

    // HELLO then enter, then ack
    start_game();
    type_word("HELLO");
    press_key(".");
    check("hello_guess", guess, 40'h48454C4C4F);
    check("hello_valid", 40'(guess_valid), 40'h1);
    ack_guess();
    check("ack_num", 40'(guess_num), 40'h1);
    check("ack_cnt", 40'(letter_cnt), 40'h0);
    check("ack_entry", 40'(q_Entry), 40'h1);

    // sixth letter ignored, delete clears last slot
    type_word("ABCDE");
    press_key("Z");
    check("full_ignore", guess, 40'h4142434445);
    press_key(",");
    check("del_cnt", 40'(letter_cnt), 40'h4);
    check("del_guess", guess, 40'h4142434420);

    // enter too early, delete when empty
    press_key(",");
    press_key(".");
    check("early_enter", 40'({q_Entry, letter_cnt}), 40'hB);
    repeat (4) press_key(",");
    check("empty_del_cnt", 40'(letter_cnt), 40'h0);
    check("empty_del_guess", guess, BLANK);

    // held Sel yields a single press
    @(negedge Clk); curr_letter = "A"; Sel = 1;
    repeat (20) @(negedge Clk);
    Sel = 0;
    check("hold_cnt", 40'(letter_cnt), 40'h1);
    check("hold_guess", guess, 40'h4120202020);

    // play out the remaining guesses
    press_key("B"); press_key("C"); press_key("D"); press_key("E");
    press_key(".");
    ack_guess();
    for (int g = 3; g <= MAXG; g++) begin
      type_word("WORDS");
      press_key(".");
      ack_guess();
    end
    check("done_state", 40'({q_I, q_Entry, q_Submit, q_Done}), 40'h1);
    check("done_num", 40'(guess_num), 40'(MAXG));
    press_key("Q");
    check("done_press", 40'(letter_cnt), 40'h0);
    @(negedge Clk); Ack = 1;
    @(negedge Clk); Ack = 0;
    check("ack_idle", 40'(q_I), 40'h1);
    check("idle_num", 40'(guess_num), 40'(MAXG));

`ifdef GUESS_REJECT_EN
    start_game();
    type_word("CRANE");
    press_key(".");
    @(negedge Clk); guess_ack = 1; guess_reject = 1;
    @(negedge Clk); guess_ack = 0; guess_reject = 0;
    check("reject_entry", 40'(q_Entry), 40'h1);
    check("reject_cnt", 40'(letter_cnt), 40'h5);
    check("reject_num", 40'(guess_num), 40'h0);
    check("reject_guess", guess, 40'h4352414E45);
`endif

    // reset dropped mid-submit
    start_game();
    type_word("SLATE");
    press_key(".");
    check("pre_reset_valid", 40'(guess_valid), 40'h1);
    @(negedge Clk);
    #2 reset_n = 0;
    #1;
    check("async_state", 40'({q_I, q_Entry, q_Submit, q_Done}), 40'h8);
    check("async_valid", 40'(guess_valid), 40'h0);
    check("async_guess", guess, BLANK);
    check("async_cnt", 40'(letter_cnt), 40'h0);
    @(negedge Clk);
    reset_n = 1;

    // randomized play
    repeat (4000) begin
      int r;
      @(negedge Clk);
      r = $urandom_range(0, 9);
      if (r < 6)       curr_letter = 8'(8'h41 + $urandom_range(0, 25));
      else if (r == 6) curr_letter = ",";
      else if (r < 9)  curr_letter = ".";
      else             curr_letter = 8'($urandom_range(0, 255));
      Sel       = 1'($urandom_range(0, 1));
      Start     = ($urandom_range(0, 3) == 0);
      Ack       = ($urandom_range(0, 3) == 0);
      guess_ack = ($urandom_range(0, 2) == 0);
`ifdef GUESS_REJECT_EN
      guess_reject = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 999) == 0) begin
        #2 reset_n = 0;
        @(negedge Clk) reset_n = 1;
      end
    end

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
